neuron_config_writer: RTL and testbench
=======================================

# neuron_config_writer

Initiator side of the neuron configuration port: accepts a packetised word stream (header, weights, bias) over a valid/ready handshake and drives a neuron's `weightValid`/`weightWriteEn`/`weightData`, `biasWriteEn`/`biasData` and `config_layer_number`/`config_neuron_number` inputs. It sits between the on-board loader (UART/ROM reader) and the neuron array, replacing the tied-off configuration ports used when weights come from `.mif` files. Each neuron compares `config_layer_number`/`config_neuron_number` against its own parameters and captures only matching writes.

## Interface
- `numWeights`, 256: maximum weights per neuron; also the width source for the weight counter, `$clog2(numWeights+1)`.
- `layerBits`, 8: header bits carrying the layer number.
- `neuronBits`, 8: header bits carrying the neuron number.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- `cfg_data`  input  32  stream word.
- `cfg_valid`  input  1  `cfg_data` is valid.
- `cfg_ready`  output  1  writer can accept a word; a transfer happens when `cfg_valid & cfg_ready` at a rising edge.
- `abort`  input  1  synchronous; drops the current packet.
- `weightValid`  output  1  one-cycle pulse accompanying each weight write.
- `weightWriteEn`  output  1  one-cycle weight write strobe, identical timing to `weightValid`.
- `weightData`  output  32  weight word, passed through unmodified.
- `biasWriteEn`  output  1  one-cycle bias write strobe.
- `biasData`  output  32  bias word, passed through unmodified.
- `config_layer_number`  output  32  target layer, zero-extended from the header.
- `config_neuron_number`  output  32  target neuron, zero-extended from the header.
- `busy`  output  1  high outside IDLE.
- `done`  output  1  one-cycle pulse when a packet completes with its bias write.
- `err`  output  1  sticky; set on an oversized header and cleared by the next accepted header.

## Operation
- Packet format:
  - Header word: `[31:24]` layer, `[23:16]` neuron, `[15:0]` weight count N.
  - Then N weight words, then exactly one bias word.
- States:
  - **IDLE**: `cfg_ready=1`. On transfer, latch layer/neuron into `config_*` and load count N.
    - N > `numWeights`: set `err`, stay in IDLE, latch nothing into `config_*`.
    - N == 0: go to BIAS.
    - Otherwise: go to WEIGHT.
    - Any valid header (N ≤ `numWeights`) clears `err`.
  - **WEIGHT**: `cfg_ready=1`. Each transfer registers the word into `weightData`, pulses `weightValid`/`weightWriteEn` in the next cycle, and decrements the count. The transfer that brings the count to 0 moves the state to BIAS.
  - **BIAS**: `cfg_ready=1`. The transfer registers `biasData`, pulses `biasWriteEn`, and moves to DONE.
  - **DONE**: `cfg_ready=0`, `done=1` for one cycle, then IDLE.
- `abort`:
  - In WEIGHT or BIAS: go to IDLE in the next cycle and discard any word presented in the same cycle (no strobe).
  - Strobes already issued are not retracted. `config_*` keep their values.
  - In IDLE or DONE: ignored.
- Back-to-back writes: a transfer every cycle gives a strobe every cycle; `cfg_valid` gaps give strobe gaps. Count decrements only on transfers.
- `weightData`, `biasData` and `config_*` hold their last value between strobes.
- Strobes are never asserted simultaneously (`weightWriteEn & biasWriteEn` == 0 always).

## Timing
- Reset (asynchronous, `reset_n=0`):
  - State IDLE, count 0.
  - All strobes, `done`, `busy` and `err` = 0.
  - `weightData`, `biasData` and `config_*` = 0.
  - `cfg_ready` = 1 from the first edge after release. Reset mid-packet drops the packet with no further strobes.
- Latency: a transfer at edge k asserts the corresponding strobe and data during cycle k+1 (one register stage).
- The header transfer at edge k updates `config_*` and `busy` in cycle k+1. `config_*` are therefore stable at least one cycle before the first weight strobe.
- The bias transfer at edge k gives `biasWriteEn=1`, `done=1` and `cfg_ready=0` in cycle k+1, and IDLE with `cfg_ready=1` in cycle k+2.
- Minimum packet duration with N weights and continuous valid: N+3 cycles from the header edge to the next header acceptance.
- `cfg_ready` is a function of the state only; it does not depend combinationally on `cfg_valid`.

## Test plan
- **Normal packet**: reset; header `32'h0102_0003` followed by weights 0x11, 0x22, 0x33 and bias 0x44, with continuous valid. Required response:
  - `config_layer_number=1` and `config_neuron_number=2` from cycle k+1.
  - Three consecutive `weightWriteEn` pulses with data 0x11, 0x22, 0x33.
  - Then `biasWriteEn` with 0x44 and `done` in the same cycle.
  - `cfg_ready` low for exactly one cycle.
- **Empty packet**: header `32'h0000_0000` then bias 0x7F. Required response: no weight strobes; one `biasWriteEn` with 0x7F; `done` pulse.
- **Oversize header**: header with N=257 and `numWeights=256`. Required response:
  - `err=1`; state stays IDLE; `config_*` unchanged; no strobes.
  - A following valid header (N=1) clears `err`.
- **Stalled stream**: N=4 with `cfg_valid` toggled 1,0,0,1,1,0,1. Required response:
  - Exactly 4 weight strobes, each one cycle after the corresponding transfer.
  - No strobe in stall cycles; count is correct at the bias word.
- **Abort**: N=4; assert `abort` together with the third weight word. Required response:
  - Exactly 2 weight strobes; no bias strobe; no `done`.
  - `busy=0` the next cycle; a fresh header is accepted immediately.
- **Async reset mid-packet**: pull `reset_n` low between clock edges during WEIGHT. Required response:
  - All outputs are immediately at their reset values (`cfg_ready=0` while asserted).
  - After release: `cfg_ready=1` and no residual strobes.

Source files
------------

// File: rtl/neuron_config_writer.sv
// neuron_config_writer
// Initiator side of the neuron configuration port. Takes a packetised word
// stream (header, N weights, one bias) over valid/ready and turns it into
// registered weight/bias write strobes plus the layer/neuron target numbers
// that every neuron compares against its own identity.
module neuron_config_writer #(
    parameter int numWeights = 256,
    parameter int layerBits  = 8,
    parameter int neuronBits = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cfg_data,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        abort,
    output logic        weightValid,
    output logic        weightWriteEn,
    output logic [31:0] weightData,
    output logic        biasWriteEn,
    output logic [31:0] biasData,
    output logic [31:0] config_layer_number,
    output logic [31:0] config_neuron_number,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int                 CNT_W    = $clog2(numWeights + 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [16:0]        MAX_N    = 17'(numWeights);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WEIGHT = 2'd1,
        S_BIAS   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_count;

    logic             r_cfg_ready;
    logic             r_weight_we;
    logic [31:0]      r_weight_data;
    logic             r_bias_we;
    logic [31:0]      r_bias_data;
    logic [31:0]      r_layer;
    logic [31:0]      r_neuron;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    // Header decode: the count field is widened by one bit so the
    // oversize compare cannot wrap.
    logic             w_xfer;
    logic [16:0]      w_hdr_n;
    logic             w_oversize;
    logic             w_hdr_zero;

    logic             w_hdr_ok;
    logic             w_hdr_bad;
    logic             w_weight_we;
    logic             w_bias_we;
    logic             w_ready_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // cfg_ready is registered, so a transfer never depends combinationally
    // on cfg_valid and reads low while reset is asserted.
    assign w_xfer     = cfg_valid & r_cfg_ready;
    assign w_hdr_n    = {1'b0, cfg_data[15:0]};
    assign w_oversize = (w_hdr_n > MAX_N);
    assign w_hdr_zero = (cfg_data[15:0] == 16'd0);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort only matters while inside a packet body.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer && !w_oversize) begin
                    if (w_hdr_zero) begin
                        w_next_state = S_BIAS;
                    end else begin
                        w_next_state = S_WEIGHT;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WEIGHT: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (w_xfer && (r_count == CNT_ONE)) begin
                    w_next_state = S_BIAS;
                end else begin
                    w_next_state = S_WEIGHT;
                end
            end
            S_BIAS: begin
                if (abort) begin
                    w_next_state = S_IDLE;
                end else if (w_xfer) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_BIAS;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output decode: next-cycle values of every registered output.
    always_comb begin
        w_hdr_ok    = 1'b0;
        w_hdr_bad   = 1'b0;
        w_weight_we = 1'b0;
        w_bias_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_hdr_ok  = w_xfer & ~w_oversize;
                w_hdr_bad = w_xfer &  w_oversize;
            end
            S_WEIGHT: begin
                w_weight_we = w_xfer & ~abort;
            end
            S_BIAS: begin
                w_bias_we = w_xfer & ~abort;
            end
            S_DONE: begin
                w_weight_we = 1'b0;
            end
            default: begin
                w_weight_we = 1'b0;
            end
        endcase
        w_ready_nxt = (w_next_state != S_DONE);
        w_busy_nxt  = (w_next_state != S_IDLE);
        w_done_nxt  = (w_next_state == S_DONE);
    end

    // Output and datapath registers: one register stage from transfer to strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_ready   <= 1'b0;
            r_weight_we   <= 1'b0;
            r_weight_data <= 32'd0;
            r_bias_we     <= 1'b0;
            r_bias_data   <= 32'd0;
            r_layer       <= 32'd0;
            r_neuron      <= 32'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_cfg_ready <= w_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_weight_we <= w_weight_we;
            r_bias_we   <= w_bias_we;
            if (w_weight_we) begin
                r_weight_data <= cfg_data;
            end
            if (w_bias_we) begin
                r_bias_data <= cfg_data;
            end
            if (w_hdr_ok) begin
                r_layer  <= 32'(cfg_data[31 -: layerBits]);
                r_neuron <= 32'(cfg_data[23 -: neuronBits]);
                r_err    <= 1'b0;
            end else if (w_hdr_bad) begin
                r_err    <= 1'b1;
            end
        end
    end

    // Weight counter: loaded by an accepted header, decremented per weight transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= CNT_ZERO;
        end else if (w_hdr_ok) begin
            r_count <= CNT_W'(cfg_data[15:0]);
        end else if (w_weight_we) begin
            r_count <= r_count - CNT_ONE;
        end
    end

    assign cfg_ready            = r_cfg_ready;
    assign weightValid          = r_weight_we;
    assign weightWriteEn        = r_weight_we;
    assign weightData           = r_weight_data;
    assign biasWriteEn          = r_bias_we;
    assign biasData             = r_bias_data;
    assign config_layer_number  = r_layer;
    assign config_neuron_number = r_neuron;
    assign busy                 = r_busy;
    assign done                 = r_done;
    assign err                  = r_err;

endmodule

// File: tb/tb_neuron_config_writer.sv
// Testbench for neuron_config_writer: a packet-level reference model is
// checked against the DUT every cycle, plus hand-computed expectations
// for each directed scenario.
module tb_neuron_config_writer;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic [31:0] cfg_data  = 32'd0;
    logic        cfg_valid = 1'b0;
    logic        abort     = 1'b0;
    logic        cfg_ready;
    logic        weightValid;
    logic        weightWriteEn;
    logic [31:0] weightData;
    logic        biasWriteEn;
    logic [31:0] biasData;
    logic [31:0] config_layer_number;
    logic [31:0] config_neuron_number;
    logic        busy;
    logic        done;
    logic        err;

    neuron_config_writer #(
        .numWeights(256),
        .layerBits (8),
        .neuronBits(8)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .cfg_data            (cfg_data),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .abort               (abort),
        .weightValid         (weightValid),
        .weightWriteEn       (weightWriteEn),
        .weightData          (weightData),
        .biasWriteEn         (biasWriteEn),
        .biasData            (biasData),
        .config_layer_number (config_layer_number),
        .config_neuron_number(config_neuron_number),
        .busy                (busy),
        .done                (done),
        .err                 (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: tracks how many words of the current packet remain
    // (weights plus the bias), or 0 while waiting for a header.
    int          m_need    = 0;
    bit          m_done_ph = 1'b0;
    bit          m_xfer;
    int          m_n;
    logic        e_ready  = 1'b0;
    logic        e_busy   = 1'b0;
    logic        e_done   = 1'b0;
    logic        e_err    = 1'b0;
    logic        e_wwe    = 1'b0;
    logic        e_bwe    = 1'b0;
    logic [31:0] e_wdata  = 32'd0;
    logic [31:0] e_bdata  = 32'd0;
    logic [31:0] e_layer  = 32'd0;
    logic [31:0] e_neuron = 32'd0;

    // Observed-activity counters used by the directed expectations.
    int          cnt_w    = 0;
    int          cnt_b    = 0;
    int          cnt_d    = 0;
    int          cnt_db   = 0;
    int          cnt_rlow = 0;
    logic [31:0] wq[$];

    // Model step on each edge, then compare all outputs just after the edge.
    always @(posedge clk) begin
        if (!reset_n) begin
            m_need = 0; m_done_ph = 1'b0;
            e_ready = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
            e_wwe = 1'b0; e_bwe = 1'b0; e_wdata = 32'd0; e_bdata = 32'd0;
            e_layer = 32'd0; e_neuron = 32'd0;
        end else begin
            m_xfer = cfg_valid && e_ready;
            e_wwe = 1'b0; e_bwe = 1'b0; e_done = 1'b0; e_ready = 1'b1;
            if (m_done_ph) begin
                m_done_ph = 1'b0;
                e_busy    = 1'b0;
            end else if (m_need == 0) begin
                if (m_xfer) begin
                    m_n = int'(cfg_data[15:0]);
                    if (m_n > 256) begin
                        e_err = 1'b1;
                    end else begin
                        e_err    = 1'b0;
                        e_layer  = {24'd0, cfg_data[31:24]};
                        e_neuron = {24'd0, cfg_data[23:16]};
                        m_need   = m_n + 1;
                        e_busy   = 1'b1;
                    end
                end
            end else if (abort) begin
                m_need = 0;
                e_busy = 1'b0;
            end else if (m_xfer) begin
                if (m_need > 1) begin
                    e_wwe   = 1'b1;
                    e_wdata = cfg_data;
                    m_need  = m_need - 1;
                end else begin
                    e_bwe     = 1'b1;
                    e_bdata   = cfg_data;
                    e_done    = 1'b1;
                    e_ready   = 1'b0;
                    m_need    = 0;
                    m_done_ph = 1'b1;
                end
            end
        end
        #1;
        chk("cfg_ready", cfg_ready, e_ready);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("err", err, e_err);
        chk("weightWriteEn", weightWriteEn, e_wwe);
        chk("weightValid", weightValid, e_wwe);
        chk("biasWriteEn", biasWriteEn, e_bwe);
        chk("weightData", weightData, e_wdata);
        chk("biasData", biasData, e_bdata);
        chk("layer", config_layer_number, e_layer);
        chk("neuron", config_neuron_number, e_neuron);
        chk("strobe_excl", 32'(weightWriteEn & biasWriteEn), 32'd0);
        if (reset_n) begin
            if (weightWriteEn) begin cnt_w++; wq.push_back(weightData); end
            if (biasWriteEn) cnt_b++;
            if (done) cnt_d++;
            if (done && biasWriteEn) cnt_db++;
            if (!cfg_ready) cnt_rlow++;
        end
    end

    task automatic send(input logic [31:0] d, input logic v, input logic a);
        @(negedge clk);
        cfg_data  = d;
        cfg_valid = v;
        abort     = a;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(32'd0, 1'b0, 1'b0);
    endtask

    task automatic clr();
        cnt_w = 0; cnt_b = 0; cnt_d = 0; cnt_db = 0; cnt_rlow = 0;
        wq.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wdata", weightData, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        chk("rel_ready", 32'(cfg_ready), 32'd1);

        // Normal packet
        clr();
        send(32'h0102_0003, 1'b1, 1'b0);
        send(32'h0000_0011, 1'b1, 1'b0);
        chk("norm_layer_k1", config_layer_number, 32'd1);
        chk("norm_neuron_k1", config_neuron_number, 32'd2);
        send(32'h0000_0022, 1'b1, 1'b0);
        send(32'h0000_0033, 1'b1, 1'b0);
        send(32'h0000_0044, 1'b1, 1'b0);
        idle(3);
        chk("norm_wcnt", 32'(cnt_w), 32'd3);
        chk("norm_w0", wq[0], 32'h11);
        chk("norm_w1", wq[1], 32'h22);
        chk("norm_w2", wq[2], 32'h33);
        chk("norm_bcnt", 32'(cnt_b), 32'd1);
        chk("norm_bias", biasData, 32'h44);
        chk("norm_done_with_bias", 32'(cnt_db), 32'd1);
        chk("norm_ready_low", 32'(cnt_rlow), 32'd1);
        chk("model_layer", e_layer, 32'd1);
        chk("model_neuron", e_neuron, 32'd2);

        // Empty packet
        clr();
        send(32'h0000_0000, 1'b1, 1'b0);
        send(32'h0000_007F, 1'b1, 1'b0);
        idle(3);
        chk("empty_wcnt", 32'(cnt_w), 32'd0);
        chk("empty_bcnt", 32'(cnt_b), 32'd1);
        chk("empty_bias", biasData, 32'h7F);
        chk("empty_done", 32'(cnt_d), 32'd1);

        // Oversize header, then the N=256 boundary, then another oversize
        clr();
        send({8'h05, 8'h06, 16'd257}, 1'b1, 1'b0);
        idle(2);
        chk("over_err", 32'(err), 32'd1);
        chk("over_busy", 32'(busy), 32'd0);
        chk("over_layer", config_layer_number, 32'd0);
        chk("over_neuron", config_neuron_number, 32'd0);
        chk("model_err", 32'(e_err), 32'd1);
        send({8'h0A, 8'h0B, 16'd256}, 1'b1, 1'b0);
        send(32'h0000_0099, 1'b1, 1'b1);
        chk("max_err_clr", 32'(err), 32'd0);
        chk("max_busy", 32'(busy), 32'd1);
        chk("max_layer", config_layer_number, 32'h0A);
        idle(2);
        send({8'h0C, 8'h0D, 16'hFFFF}, 1'b1, 1'b0);
        idle(2);
        chk("over2_err", 32'(err), 32'd1);
        chk("over2_layer", config_layer_number, 32'h0A);
        send({8'h03, 8'h04, 16'd1}, 1'b1, 1'b0);
        send(32'h0000_00AA, 1'b1, 1'b0);
        chk("n1_err_clr", 32'(err), 32'd0);
        send(32'h0000_00BB, 1'b1, 1'b0);
        idle(2);
        chk("over_wcnt", 32'(cnt_w), 32'd1);
        chk("n1_layer", config_layer_number, 32'h03);
        chk("n1_bias", biasData, 32'hBB);

        // Stalled stream: valid pattern 1,0,0,1,1,0,1 then bias
        clr();
        send({8'h01, 8'h01, 16'd4}, 1'b1, 1'b0);
        send(32'hA1, 1'b1, 1'b0);
        send(32'hEE, 1'b0, 1'b0);
        send(32'hEF, 1'b0, 1'b0);
        send(32'hA2, 1'b1, 1'b0);
        send(32'hA3, 1'b1, 1'b0);
        send(32'hF0, 1'b0, 1'b0);
        send(32'hA4, 1'b1, 1'b0);
        send(32'hB4, 1'b1, 1'b0);
        idle(3);
        chk("stall_wcnt", 32'(cnt_w), 32'd4);
        chk("stall_w3", wq[3], 32'hA4);
        chk("stall_bcnt", 32'(cnt_b), 32'd1);
        chk("stall_bias", biasData, 32'hB4);

        // Abort on the third weight, fresh header right after
        clr();
        send({8'h02, 8'h02, 16'd4}, 1'b1, 1'b0);
        send(32'hC1, 1'b1, 1'b0);
        send(32'hC2, 1'b1, 1'b0);
        send(32'hC3, 1'b1, 1'b1);
        send({8'h07, 8'h08, 16'd0}, 1'b1, 1'b0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wcnt", 32'(cnt_w), 32'd2);
        chk("abort_layer_kept", config_layer_number, 32'h02);
        send(32'h0000_0055, 1'b1, 1'b0);
        chk("fresh_layer", config_layer_number, 32'h07);
        idle(3);
        chk("abort_total_w", 32'(cnt_w), 32'd2);
        chk("abort_total_b", 32'(cnt_b), 32'd1);
        chk("abort_total_d", 32'(cnt_d), 32'd1);

        // Async reset in the middle of the weight phase
        clr();
        send({8'h09, 8'h09, 16'd3}, 1'b1, 1'b0);
        send(32'hD1, 1'b1, 1'b0);
        send(32'hD2, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_ready", 32'(cfg_ready), 32'd0);
        chk("ar_wwe", 32'(weightWriteEn), 32'd0);
        chk("ar_wdata", weightData, 32'd0);
        chk("ar_layer", config_layer_number, 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        send(32'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        clr();
        idle(3);
        chk("ar_post_ready", 32'(cfg_ready), 32'd1);
        chk("ar_post_w", 32'(cnt_w), 32'd0);
        chk("ar_post_b", 32'(cnt_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
